// File: rtl/al_logic_clkswitch_ctrl_pkg.sv
// al_logic_clkswitch_ctrl_pkg: shared FSM state encoding and width helper for the clock-switch controller
package al_logic_clkswitch_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/al_logic_clkmon.sv
// al_logic_clkmon: heartbeat synchronizer, both-edge detector and per-window saturating edge counter
module al_logic_clkmon
  import al_logic_clkswitch_ctrl_pkg::*;
#(
  parameter int MIN_EDGES = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic hb,
  input  logic win_end,
  output logic good
);
  localparam int CW = clog2(MIN_EDGES + 1);
  logic [2:0]    sh;
  logic [CW-1:0] cnt;
  logic [CW:0]   total;
  logic          edg;
  assign edg   = sh[2] ^ sh[1];
  // an edge seen on the terminal cycle still belongs to the closing window
  assign total = {1'b0, cnt} + {{CW{1'b0}}, edg};
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sh   <= '0;
      cnt  <= '0;
      good <= 1'b0;
    end else begin
      sh <= {sh[1:0], hb};
      if (win_end) begin
        good <= total >= (CW+1)'(MIN_EDGES);
        cnt  <= '0;
      end else if (edg && cnt != CW'(MIN_EDGES)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/al_logic_clkswitch_ctrl.sv
// al_logic_clkswitch_ctrl: qualifies two clocks and drives the clock-mux select with request handshake and auto failover
module al_logic_clkswitch_ctrl
  import al_logic_clkswitch_ctrl_pkg::*;
#(
  parameter int WINDOW    = 256,
  parameter int MIN_EDGES = 16,
  parameter int SETTLE    = 8,
  parameter bit PRESELECT = 1'b0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       hb0,
  input  logic       hb1,
  input  logic       req_vld,
  input  logic       req_sel,
  output logic       req_rdy,
  input  logic       auto_en,
  output logic       s,
  output logic [1:0] good,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       lost
);
  localparam int WW = clog2(WINDOW);
  localparam int SW = clog2(SETTLE) + 1;
  state_t        state, state_n;
  logic [WW-1:0] wcnt;
  logic [SW-1:0] scnt, scnt_n;
  logic [1:0]    good_d;
  logic          win_end, fo, s_n, sel_q, sel_n, done_n, err_n, lost_n;
  assign win_end = wcnt == WW'(WINDOW - 1);
  al_logic_clkmon #(.MIN_EDGES(MIN_EDGES)) u_mon0 (
    .clk(clk), .rstn(rstn), .hb(hb0), .win_end(win_end), .good(good[0])
  );
  al_logic_clkmon #(.MIN_EDGES(MIN_EDGES)) u_mon1 (
    .clk(clk), .rstn(rstn), .hb(hb1), .win_end(win_end), .good(good[1])
  );
  // failover outranks a same-cycle request, so it also gates req_rdy
  assign fo      = auto_en & ~good[s] & good[~s];
  assign req_rdy = (state == ST_IDLE) & ~fo;
  assign busy    = state != ST_IDLE;
  always_comb begin
    state_n = state;
    s_n     = s;
    sel_n   = sel_q;
    scnt_n  = scnt;
    done_n  = 1'b0;
    err_n   = 1'b0;
    lost_n  = good_d[s] & ~good[s];
    case (state)
      ST_IDLE: begin
        if (fo) begin
          s_n     = ~s;
          lost_n  = 1'b1;
          scnt_n  = SW'(SETTLE - 1);
          state_n = ST_SETTLE;
        end else if (req_vld) begin
          sel_n   = req_sel;
          state_n = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (sel_q == s || !good[sel_q]) begin
          done_n  = 1'b1;
          err_n   = sel_q != s;
          state_n = ST_IDLE;
        end else begin
          s_n     = sel_q;
          scnt_n  = SW'(SETTLE - 1);
          state_n = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        done_n  = scnt == '0;
        scnt_n  = scnt == '0 ? scnt : scnt - 1'b1;
        state_n = scnt == '0 ? ST_IDLE : ST_SETTLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= ST_IDLE;
      wcnt   <= '0;
      scnt   <= '0;
      s      <= PRESELECT;
      sel_q  <= 1'b0;
      good_d <= 2'b00;
      done   <= 1'b0;
      err    <= 1'b0;
      lost   <= 1'b0;
    end else begin
      state  <= state_n;
      wcnt   <= wcnt + 1'b1;
      scnt   <= scnt_n;
      s      <= s_n;
      sel_q  <= sel_n;
      good_d <= good;
      done   <= done_n;
      err    <= err_n;
      lost   <= lost_n;
    end
  end
endmodule

// File: tb/tb_al_logic_clkswitch_ctrl.sv
// tb_al_logic_clkswitch_ctrl: directed and randomized checks against a schedule-based reference model
module tb_al_logic_clkswitch_ctrl;
  localparam int WINDOW    = 256;
  localparam int MIN_EDGES = 16;
  localparam int SETTLE    = 8;
  localparam bit PRESELECT = 1'b0;
  localparam int FAR       = 32'h7fffffff;
  logic       clk = 1'b0, rstn = 1'b0, hb0 = 1'b0, hb1 = 1'b0;
  logic       req_vld = 1'b0, req_sel = 1'b0, auto_en = 1'b0;
  logic       req_rdy, s, busy, done, err, lost;
  logic [1:0] good;
  always #5 clk = ~clk;
  al_logic_clkswitch_ctrl #(
    .WINDOW(WINDOW), .MIN_EDGES(MIN_EDGES), .SETTLE(SETTLE), .PRESELECT(PRESELECT)
  ) dut (
    .clk(clk), .rstn(rstn), .hb0(hb0), .hb1(hb1), .req_vld(req_vld), .req_sel(req_sel),
    .req_rdy(req_rdy), .auto_en(auto_en), .s(s), .good(good), .busy(busy), .done(done),
    .err(err), .lost(lost)
  );
  int nvec = 0, nfail = 0;
  int e = 0, last_done = -1, chk_edge = -1;
  bit known = 1'b0, ms = PRESELECT, chk_sel = 1'b0;
  bit [1:0] g = 2'b00, gp = 2'b00;
  int cnt [2] = '{0, 0};
  int per [2] = '{0, 0};
  int ph  [2] = '{0, 0};
  bit hist [2][65536];
  function automatic bit hb_at(int k, int n);
    return n < 0 ? 1'b0 : hist[k][n];
  endfunction
  task automatic chk(string tag, logic [1:0] obs, logic [1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
    end
  endtask
  // one clock: advance heartbeats, check req_rdy before the edge, update model, check outputs after
  task automatic step();
    bit fo, idle, xl, xd, xe, xb;
    bit [1:0] gn;
    if (per[0] != 0 && ++ph[0] >= per[0]) begin ph[0] = 0; hb0 = ~hb0; end
    if (per[1] != 0 && ++ph[1] >= per[1]) begin ph[1] = 0; hb1 = ~hb1; end
    if (rstn) begin hist[0][e] = hb0; hist[1][e] = hb1; end
    #1;
    fo   = auto_en & ~g[ms] & g[~ms];
    idle = e > last_done;
    if (known) chk("req_rdy", {1'b0, req_rdy}, {1'b0, idle & ~fo});
    @(posedge clk);
    xl = 0; xd = 0; xe = 0; xb = 0;
    if (!rstn) begin
      known = 1; e = 0; ms = PRESELECT; g = 0; gp = 0;
      last_done = -1; chk_edge = -1; cnt = '{0, 0};
    end else begin
      xl = (idle & fo) | (gp[ms] & ~g[ms]);
      if (idle & fo) begin
        ms = ~ms;
        last_done = e + SETTLE;
      end else if (idle & req_vld) begin
        chk_edge = e + 1;
        chk_sel = req_sel;
        last_done = FAR;
      end else if (e == chk_edge) begin
        if (chk_sel == ms) last_done = e;
        else if (!g[chk_sel]) begin last_done = e; xe = 1; end
        else begin ms = chk_sel; last_done = e + SETTLE; end
      end
      xd = e == last_done;
      xb = last_done > e;
      gn = g;
      for (int k = 0; k < 2; k++) if (hb_at(k, e - 2) != hb_at(k, e - 3)) cnt[k]++;
      if (e % WINDOW == WINDOW - 1)
        for (int k = 0; k < 2; k++) begin gn[k] = cnt[k] >= MIN_EDGES; cnt[k] = 0; end
      gp = g;
      g = gn;
      e++;
    end
    #1;
    chk("s",    {1'b0, s},    {1'b0, ms});
    chk("good", good,         g);
    chk("busy", {1'b0, busy}, {1'b0, xb});
    chk("done", {1'b0, done}, {1'b0, xd});
    chk("err",  {1'b0, err},  {1'b0, xe});
    chk("lost", {1'b0, lost}, {1'b0, xl});
  endtask
  initial begin
    repeat (3) step();
    rstn = 1;
    per[0] = 4;
    repeat (300) step();
    chk("good_after_first_window", good, 2'b01);
    req_vld = 1; req_sel = 1; step();
    req_vld = 0; repeat (4) step();
    per[1] = 3;
    repeat (300) step();
    req_vld = 1; req_sel = 1; step();
    req_sel = 0; repeat (SETTLE + 5) step();
    req_vld = 0; repeat (20) step();
    req_vld = 1; req_sel = ms; step();
    req_vld = 0; repeat (12) step();
    auto_en = 1; req_vld = 1; per[0] = 0;
    repeat (600) step();
    req_vld = 0; per[0] = 4;
    repeat (600) step();
    for (int w = 0; w < 60; w++) begin
      for (int k = 0; k < 2; k++) per[k] = $urandom_range(0, 3) == 0 ? 0 : int'($urandom_range(1, 24));
      auto_en = 1'($urandom);
      for (int c = 0; c < 64; c++) begin
        req_vld = $urandom_range(0, 3) == 0;
        req_sel = 1'($urandom);
        step();
      end
    end
    req_vld = 0; auto_en = 1; per = '{0, 0};
    repeat (600) step();
    per = '{4, 4};
    repeat (600) step();
    req_vld = 1; req_sel = ~ms; step();
    req_vld = 0; repeat (4) step();
    rstn = 0; step();
    chk("reset_mid_settle_s", {1'b0, s}, {1'b0, PRESELECT});
    rstn = 1; repeat (20) step();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
